// File: rtl/rob.sv
// Reorder buffer: in-order allocate, out-of-order complete, in-order retire of one entry per cycle.
// Latency: alloc at edge N, complete at N+1, registered retire/free pulse after edge N+2.
// Backpressure: alloc_ready drops when all entries are occupied; a blocked alloc changes no state.
module rob #(
    parameter int ROB_DEPTH  = 16,
    parameter int IDX_WIDTH  = 4,
    parameter int PREG_WIDTH = 6,
    parameter int AREG_WIDTH = 5,
    parameter int PC_WIDTH   = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    input  logic                  alloc_reg_write,
    input  logic [AREG_WIDTH-1:0] alloc_rd,
    input  logic [PREG_WIDTH-1:0] alloc_prd,
    input  logic [PREG_WIDTH-1:0] alloc_old_prd,
    input  logic [PC_WIDTH-1:0]   alloc_pc,
    output logic                  alloc_ready,
    output logic [IDX_WIDTH-1:0]  alloc_idx,
    input  logic                  cmpl_valid,
    input  logic [IDX_WIDTH-1:0]  cmpl_idx,
    output logic                  retire_valid,
    output logic [AREG_WIDTH-1:0] retire_rd,
    output logic [PREG_WIDTH-1:0] retire_prd,
    output logic [PC_WIDTH-1:0]   retire_pc,
    output logic                  push_free_reg,
    output logic [PREG_WIDTH-1:0] freed_reg,
    output logic [IDX_WIDTH:0]    count,
    output logic                  empty,
    output logic                  full
);

    typedef struct packed {
        logic                  reg_write;
        logic [AREG_WIDTH-1:0] rd;
        logic [PREG_WIDTH-1:0] prd;
        logic [PREG_WIDTH-1:0] old_prd;
        logic [PC_WIDTH-1:0]   pc;
    } entry_t;

    entry_t                ent_q [ROB_DEPTH];
    entry_t                ent_d [ROB_DEPTH];
    logic [ROB_DEPTH-1:0]  valid_q, valid_d;
    logic [ROB_DEPTH-1:0]  done_q, done_d;
    logic [IDX_WIDTH-1:0]  head_q, head_d;
    logic [IDX_WIDTH-1:0]  tail_q, tail_d;
    logic [IDX_WIDTH:0]    count_q, count_d;

    logic                  retire_valid_q, retire_valid_d;
    logic [AREG_WIDTH-1:0] retire_rd_q, retire_rd_d;
    logic [PREG_WIDTH-1:0] retire_prd_q, retire_prd_d;
    logic [PC_WIDTH-1:0]   retire_pc_q, retire_pc_d;
    logic                  push_free_reg_q, push_free_reg_d;
    logic [PREG_WIDTH-1:0] freed_reg_q, freed_reg_d;

    logic   full_w;
    logic   do_alloc;
    logic   do_retire;
    entry_t head_ent;

    assign full_w    = (count_q == (IDX_WIDTH+1)'(ROB_DEPTH));
    assign do_alloc  = alloc_valid && !full_w;
    assign do_retire = valid_q[head_q] && done_q[head_q];
    assign head_ent  = ent_q[head_q];

    always_comb begin
        ent_d           = ent_q;
        valid_d         = valid_q;
        done_d          = done_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        retire_valid_d  = 1'b0;
        retire_rd_d     = '0;
        retire_prd_d    = '0;
        retire_pc_d     = '0;
        push_free_reg_d = 1'b0;
        freed_reg_d     = '0;

        if (cmpl_valid && valid_q[cmpl_idx]) begin
            done_d[cmpl_idx] = 1'b1;
        end

        // Retire looks only at registered done, so a head completing this edge waits one cycle.
        if (do_retire) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            head_d          = head_q + IDX_WIDTH'(1);
            retire_valid_d  = 1'b1;
            retire_rd_d     = head_ent.rd;
            retire_prd_d    = head_ent.prd;
            retire_pc_d     = head_ent.pc;
            push_free_reg_d = head_ent.reg_write && (head_ent.rd != '0);
            freed_reg_d     = head_ent.old_prd;
        end

        if (do_alloc) begin
            ent_d[tail_q] = '{reg_write: alloc_reg_write, rd: alloc_rd, prd: alloc_prd,
                              old_prd: alloc_old_prd, pc: alloc_pc};
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            tail_d          = tail_q + IDX_WIDTH'(1);
        end

        count_d = count_q + (IDX_WIDTH+1)'(do_alloc) - (IDX_WIDTH+1)'(do_retire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q         <= '0;
            done_q          <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            retire_valid_q  <= 1'b0;
            retire_rd_q     <= '0;
            retire_prd_q    <= '0;
            retire_pc_q     <= '0;
            push_free_reg_q <= 1'b0;
            freed_reg_q     <= '0;
        end else begin
            valid_q         <= valid_d;
            done_q          <= done_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            retire_valid_q  <= retire_valid_d;
            retire_rd_q     <= retire_rd_d;
            retire_prd_q    <= retire_prd_d;
            retire_pc_q     <= retire_pc_d;
            push_free_reg_q <= push_free_reg_d;
            freed_reg_q     <= freed_reg_d;
        end
    end

    // Payload is qualified by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign alloc_ready   = !full_w;
    assign alloc_idx     = tail_q;
    assign count         = count_q;
    assign empty         = (count_q == '0);
    assign full          = full_w;
    assign retire_valid  = retire_valid_q;
    assign retire_rd     = retire_rd_q;
    assign retire_prd    = retire_prd_q;
    assign retire_pc     = retire_pc_q;
    assign push_free_reg = push_free_reg_q;
    assign freed_reg     = freed_reg_q;

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: stimulus pushes expected retirements in program order,
// a negedge monitor pops and compares on every retire pulse.
module tb_rob;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_valid;
    logic        alloc_reg_write;
    logic [4:0]  alloc_rd;
    logic [5:0]  alloc_prd;
    logic [5:0]  alloc_old_prd;
    logic [11:0] alloc_pc;
    logic        alloc_ready;
    logic [3:0]  alloc_idx;
    logic        cmpl_valid;
    logic [3:0]  cmpl_idx;
    logic        retire_valid;
    logic [4:0]  retire_rd;
    logic [5:0]  retire_prd;
    logic [11:0] retire_pc;
    logic        push_free_reg;
    logic [5:0]  freed_reg;
    logic [4:0]  count;
    logic        empty;
    logic        full;

    always #5 clk = ~clk;

    rob dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_reg_write(alloc_reg_write),
        .alloc_rd(alloc_rd), .alloc_prd(alloc_prd), .alloc_old_prd(alloc_old_prd),
        .alloc_pc(alloc_pc), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx),
        .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_prd(retire_prd),
        .retire_pc(retire_pc), .push_free_reg(push_free_reg), .freed_reg(freed_reg),
        .count(count), .empty(empty), .full(full)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [5:0]  prd;
        logic [5:0]  old;
        logic [11:0] pc;
        logic        push;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vec_cnt    = 0;
    int   err_cnt    = 0;
    int   retire_cnt = 0;
    int   r0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vec_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (retire_valid === 1'b1) begin
            retire_cnt++;
            if (exp_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL unexpected_retire: got pc %0h, required no retire", retire_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("retire_rd", 32'(retire_rd), 32'(mon_e.rd));
                chk("retire_prd", 32'(retire_prd), 32'(mon_e.prd));
                chk("retire_pc", 32'(retire_pc), 32'(mon_e.pc));
                chk("push_free_reg", 32'(push_free_reg), 32'(mon_e.push));
                if (mon_e.push) chk("freed_reg", 32'(freed_reg), 32'(mon_e.old));
            end
        end else begin
            chk("idle_push", 32'(push_free_reg), 32'd0);
        end
    end

    task automatic cyc(input logic av, input logic rw, input logic [4:0] rd,
                       input logic [5:0] prd, input logic [5:0] old, input logic [11:0] pc,
                       input logic cv, input logic [3:0] ci);
        alloc_valid     = av;
        alloc_reg_write = rw;
        alloc_rd        = rd;
        alloc_prd       = prd;
        alloc_old_prd   = old;
        alloc_pc        = pc;
        cmpl_valid      = cv;
        cmpl_idx        = ci;
        @(negedge clk);
        alloc_valid = 1'b0;
        cmpl_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 12'd0, 1'b0, 4'd0);
    endtask

    task automatic cmpl(input logic [3:0] idx);
        cyc(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 12'd0, 1'b1, idx);
    endtask

    task automatic alloc(input logic rw, input logic [4:0] rd, input logic [5:0] prd,
                         input logic [5:0] old, input logic [11:0] pc,
                         input logic [3:0] req_idx, input logic accept, input logic push);
        exp_t e;
        chk("alloc_idx", 32'(alloc_idx), 32'(req_idx));
        if (accept) begin
            e.rd = rd; e.prd = prd; e.old = old; e.pc = pc; e.push = push;
            exp_q.push_back(e);
        end
        cyc(1'b1, rw, rd, prd, old, pc, 1'b0, 4'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (empty !== 1'b1 && n < 200) begin
            idle(1);
            n++;
        end
        chk(name, 32'(empty), 32'd1);
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        alloc_valid = 1'b0; alloc_reg_write = 1'b0; alloc_rd = '0; alloc_prd = '0;
        alloc_old_prd = '0; alloc_pc = '0; cmpl_valid = 1'b0; cmpl_idx = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset state and idle completion
        chk("rst_retire_valid", 32'(retire_valid), 32'd0);
        chk("rst_push", 32'(push_free_reg), 32'd0);
        chk("rst_freed", 32'(freed_reg), 32'd0);
        chk("rst_rd", 32'(retire_rd), 32'd0);
        chk("rst_prd", 32'(retire_prd), 32'd0);
        chk("rst_pc", 32'(retire_pc), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ready", 32'(alloc_ready), 32'd1);
        chk("rst_idx", 32'(alloc_idx), 32'd0);
        cmpl(4'd3);
        idle(3);
        chk("idle_cmpl_retires", 32'(retire_cnt), 32'd0);
        chk("idle_cmpl_count", 32'(count), 32'd0);

        // single instruction, earliest retire timing
        alloc(1'b1, 5'd5, 6'd33, 6'd5, 12'h100, 4'd0, 1'b1, 1'b1);
        chk("single_count", 32'(count), 32'd1);
        cmpl(4'd0);
        chk("head_cmpl_no_retire", 32'(retire_valid), 32'd0);
        idle(1);
        chk("single_retire", 32'(retire_valid), 32'd1);
        chk("single_push", 32'(push_free_reg), 32'd1);
        chk("single_freed", 32'(freed_reg), 32'd5);
        chk("single_prd", 32'(retire_prd), 32'd33);
        idle(1);
        chk("single_pulse_end", 32'(retire_valid), 32'd0);
        chk("single_empty", 32'(empty), 32'd1);

        // out-of-order completion, in-order retire
        do_reset();
        alloc(1'b1, 5'd1, 6'd40, 6'd10, 12'h200, 4'd0, 1'b1, 1'b1);
        alloc(1'b1, 5'd2, 6'd41, 6'd11, 12'h201, 4'd1, 1'b1, 1'b1);
        alloc(1'b1, 5'd3, 6'd42, 6'd12, 12'h202, 4'd2, 1'b1, 1'b1);
        chk("ooo_count3", 32'(count), 32'd3);
        r0 = retire_cnt;
        cmpl(4'd2);
        cmpl(4'd1);
        idle(1);
        chk("ooo_blocked", 32'(retire_cnt - r0), 32'd0);
        cmpl(4'd0);
        chk("ooo_no_retire_yet", 32'(retire_valid), 32'd0);
        idle(1);
        chk("ooo_r0", 32'(freed_reg), 32'd10);
        chk("ooo_count2", 32'(count), 32'd2);
        idle(1);
        chk("ooo_r1", 32'(freed_reg), 32'd11);
        idle(1);
        chk("ooo_r2", 32'(freed_reg), 32'd12);
        chk("ooo_empty", 32'(empty), 32'd1);
        idle(1);
        chk("ooo_done", 32'(retire_valid), 32'd0);

        // fill, overflow, wrap, full-blocked alloc during retire
        do_reset();
        for (int i = 0; i < 16; i++)
            alloc(1'b1, 5'(i + 1), 6'(16 + i), 6'(20 + i), 12'(12'h300 + i), 4'(i), 1'b1, 1'b1);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ready", 32'(alloc_ready), 32'd0);
        chk("fill_count", 32'(count), 32'd16);
        alloc(1'b1, 5'd9, 6'd60, 6'd61, 12'h3ff, 4'd0, 1'b0, 1'b0);
        chk("overflow_count", 32'(count), 32'd16);
        chk("overflow_idx", 32'(alloc_idx), 32'd0);
        cmpl(4'd0);
        idle(1);
        chk("wrap_retire", 32'(retire_valid), 32'd1);
        chk("wrap_count", 32'(count), 32'd15);
        chk("wrap_ready", 32'(alloc_ready), 32'd1);
        alloc(1'b1, 5'd17, 6'd50, 6'd51, 12'h310, 4'd0, 1'b1, 1'b1);
        chk("wrap_full", 32'(full), 32'd1);
        cmpl(4'd1);
        alloc(1'b1, 5'd18, 6'd52, 6'd53, 12'h311, 4'd1, 1'b0, 1'b0);
        chk("full_retire_blk_count", 32'(count), 32'd15);
        chk("full_retire_blk_idx", 32'(alloc_idx), 32'd1);
        for (int i = 2; i < 16; i++) cmpl(4'(i));
        cmpl(4'd0);
        drain("fill_drain_empty");

        // store and x0 destinations, alloc concurrent with retire
        do_reset();
        alloc(1'b0, 5'd7, 6'd20, 6'd21, 12'h400, 4'd0, 1'b1, 1'b0);
        alloc(1'b1, 5'd0, 6'd22, 6'd23, 12'h401, 4'd1, 1'b1, 1'b0);
        alloc(1'b1, 5'd3, 6'd24, 6'd25, 12'h402, 4'd2, 1'b1, 1'b1);
        cmpl(4'd0);
        chk("ar_count_before", 32'(count), 32'd3);
        alloc(1'b1, 5'd4, 6'd26, 6'd27, 12'h403, 4'd3, 1'b1, 1'b1);
        chk("ar_count_after", 32'(count), 32'd3);
        chk("store_retire", 32'(retire_valid), 32'd1);
        chk("store_no_push", 32'(push_free_reg), 32'd0);
        cmpl(4'd1);
        idle(1);
        chk("x0_retire", 32'(retire_valid), 32'd1);
        chk("x0_no_push", 32'(push_free_reg), 32'd0);
        cmpl(4'd2);
        cmpl(4'd3);
        drain("store_drain_empty");

        // reset mid-stream discards in-flight work
        do_reset();
        for (int i = 0; i < 5; i++)
            alloc(1'b1, 5'(i + 1), 6'(30 + i), 6'(40 + i), 12'(12'h500 + i), 4'(i), 1'b1, 1'b1);
        cmpl(4'd1);
        cmpl(4'd3);
        chk("mid_count5", 32'(count), 32'd5);
        cmpl(4'd0);
        r0 = retire_cnt;
        do_reset();
        chk("mid_rst_no_pulse", 32'(retire_valid), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        idle(3);
        chk("mid_rst_retires", 32'(retire_cnt - r0), 32'd0);
        alloc(1'b1, 5'd9, 6'd44, 6'd45, 12'h600, 4'd0, 1'b1, 1'b1);
        cmpl(4'd0);
        drain("mid_drain_empty");

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
